// File: rtl/mem_map_pkg.sv
// Shared address map, STATUS bit layout and address decoder for the data memory responder.
package mem_map_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] ADDR_LED    = 32'h0000_0800;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0804;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_0808;
    localparam logic [31:0] ADDR_CYCLES = 32'h0000_080C;

    localparam int unsigned STATUS_CNT_LSB   = 0;
    localparam int unsigned STATUS_EMPTY_BIT = 4;
    localparam int unsigned STATUS_FULL_BIT  = 5;
    localparam int unsigned STATUS_OVF_BIT   = 6;

    typedef enum logic [2:0] {
        RegNone,
        RegRam,
        RegLed,
        RegStatus,
        RegTxData,
        RegCycles
    } region_e;

    // Word-granular decode; the two byte-offset bits never affect the region.
    function automatic region_e decode_addr(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes);
        logic [31:0] w_word;
        w_word = addr & 32'hFFFF_FFFC;
        if ((w_word - RAM_BASE) < ram_bytes) return RegRam;
        else if (w_word == ADDR_LED)         return RegLed;
        else if (w_word == ADDR_STATUS)      return RegStatus;
        else if (w_word == ADDR_TXDATA)      return RegTxData;
        else if (w_word == ADDR_CYCLES)      return RegCycles;
        else                                 return RegNone;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte transmit FIFO with wrapping pointers and an occupancy count of 0..DEPTH.
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    assign o_data = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-mapped data RAM, LED register, byte TX FIFO and optional cycle counter.
// The cycle counter at 0x80C is built only when DATA_MEM_CYCLE_COUNTER_EN is defined.
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned RAM_DEPTH  = 128,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  LED,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady
);

    localparam int unsigned RamAw    = $clog2(RAM_DEPTH);
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RamBytes = 32'(RAM_DEPTH * 4);

    region_e          w_region;
    logic [RamAw-1:0] w_ram_idx;
    logic             w_wr_ram;
    logic             w_wr_led;
    logic             w_wr_status;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [CntW-1:0]  w_count;
    logic [3:0]       w_cnt4;
    logic [31:0]      w_status;
    logic [31:0]      w_cycles;

    logic [31:0]      r_ram [RAM_DEPTH];
    logic [7:0]       r_led;
    logic             r_ovf;

    assign w_region    = decode_addr(ALUResult, RamBytes);
    assign w_ram_idx   = ALUResult[RamAw+1:2];
    assign w_wr_ram    = MemWrite && (w_region == RegRam);
    assign w_wr_led    = MemWrite && (w_region == RegLed);
    assign w_wr_status = MemWrite && (w_region == RegStatus);
    assign w_push_req  = MemWrite && (w_region == RegTxData);

    assign TxValid = !w_empty;
    assign w_pop   = TxValid && TxReady;
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (CLK),
        .i_rst_n (Reset),
        .i_push  (w_push),
        .i_data  (WriteData[7:0]),
        .i_pop   (w_pop),
        .o_data  (TxData),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge CLK) begin
        if (w_wr_ram) r_ram[w_ram_idx] <= WriteData;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_led <= 8'h00;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr_led) r_led <= WriteData[7:0];
            if (w_wr_status) r_ovf <= 1'b0;
            else if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign LED = r_led;

`ifdef DATA_MEM_CYCLE_COUNTER_EN
    logic [31:0] r_cycles;
    logic        w_wr_cycles;

    assign w_wr_cycles = MemWrite && (w_region == RegCycles);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)           r_cycles <= '0;
        else if (w_wr_cycles) r_cycles <= '0;
        else                  r_cycles <= r_cycles + 32'd1;
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    // Count field is four bits wide regardless of FIFO_DEPTH.
    assign w_cnt4 = 4'(w_count);

    always_comb begin
        w_status = '0;
        w_status[STATUS_CNT_LSB +: 4]  = w_cnt4;
        w_status[STATUS_EMPTY_BIT]     = w_empty;
        w_status[STATUS_FULL_BIT]      = w_full;
        w_status[STATUS_OVF_BIT]       = r_ovf;
    end

    always_comb begin
        ReadData = '0;
        unique case (w_region)
            RegRam:    ReadData = r_ram[w_ram_idx];
            RegLed:    ReadData = {24'h0, r_led};
            RegStatus: ReadData = w_status;
            RegCycles: ReadData = w_cycles;
            default:   ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized traffic
// checked against a queue/array reference model.
module tb_data_mem_responder;

    localparam int unsigned RAM_DEPTH  = 128;
    localparam int unsigned FIFO_DEPTH = 8;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic        TxReady = 1'b0;
    logic [31:0] ReadData;
    logic [7:0]  LED;
    logic [7:0]  TxData;
    logic        TxValid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_ram [RAM_DEPTH];
    logic [7:0]  q [$];
    logic [7:0]  m_led;
    bit          m_ovf;
    logic [31:0] m_cycles;

    data_mem_responder #(
        .RAM_DEPTH  (RAM_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .LED       (LED),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .TxReady   (TxReady)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        int unsigned n;
        w = a & 32'hFFFF_FFFC;
        n = q.size();
        if (w < RAM_DEPTH * 4) return m_ram[int'(w >> 2)];
        case (w)
            32'h800: return {24'h0, m_led};
            32'h804: return (m_ovf ? 32'h40 : 32'h0) | ((n == FIFO_DEPTH) ? 32'h20 : 32'h0) |
                            ((n == 0) ? 32'h10 : 32'h0) | 32'(n % 16);
`ifdef DATA_MEM_CYCLE_COUNTER_EN
            32'h80C: return m_cycles;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_led    = 8'h00;
        m_ovf    = 1'b0;
        m_cycles = 32'h0;
    endtask

    task automatic drive(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input bit rdy);
        MemWrite  = we;
        ALUResult = addr;
        WriteData = wd;
        TxReady   = rdy;
        #2;
    endtask

    // One clock edge: model decisions are taken from pre-edge state and current inputs.
    task automatic tick();
        logic [31:0] w;
        int unsigned n0;
        bit          pop;
        bit          push_req;
        w        = ALUResult & 32'hFFFF_FFFC;
        n0       = q.size();
        pop      = (n0 != 0) && TxReady;
        push_req = MemWrite && (w == 32'h808);
        @(posedge CLK);
        if (pop) void'(q.pop_front());
        if (MemWrite) begin
            if (w < RAM_DEPTH * 4) m_ram[int'(w >> 2)] = WriteData;
            else if (w == 32'h800) m_led = WriteData[7:0];
            else if (w == 32'h804) m_ovf = 1'b0;
        end
        if (push_req) begin
            if (n0 < FIFO_DEPTH || pop) q.push_back(WriteData[7:0]);
            else m_ovf = 1'b1;
        end
        if (MemWrite && w == 32'h80C) m_cycles = 32'h0;
        else m_cycles = m_cycles + 32'd1;
        #1;
    endtask

    task automatic check_outputs();
        check("rand_rdata", ReadData, m_read(ALUResult));
        check("rand_txvalid", {31'h0, TxValid}, (q.size() != 0) ? 32'h1 : 32'h0);
        check("rand_txdata", {24'h0, TxData}, (q.size() != 0) ? {24'h0, q[0]} : 32'h0);
        check("rand_led", {24'h0, LED}, {24'h0, m_led});
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  last;
        int unsigned sel;

        model_reset();
        #1;
        drive(0, 32'h804, 32'h0, 0);
        check("rst_txvalid", {31'h0, TxValid}, 32'h0);
        check("rst_led", {24'h0, LED}, 32'h0);
        check("rst_txdata", {24'h0, TxData}, 32'h0);
        check("rst_status", ReadData, 32'h10);
        @(posedge CLK);
        #1;
        Reset = 1'b1;

        for (int i = 0; i < int'(RAM_DEPTH); i++) begin
            drive(1, 32'(i * 4), $urandom, 0);
            tick();
        end

        // Word store/load and byte-offset aliasing.
        drive(1, 32'h010, 32'hDEAD_BEEF, 0);
        tick();
        drive(0, 32'h010, 32'h0, 0);
        check("ram_load", ReadData, 32'hDEAD_BEEF);
        drive(0, 32'h013, 32'h0, 0);
        check("ram_load_offset", ReadData, 32'hDEAD_BEEF);
        drive(1, 32'h010, 32'h1234_5678, 0);
        check("ram_rdw_old", ReadData, 32'hDEAD_BEEF);
        tick();
        drive(0, 32'h010, 32'h0, 0);
        check("ram_rdw_new", ReadData, 32'h1234_5678);

        // Fill with TxReady low, then overflow.
        for (int b = 8'h41; b <= 8'h49; b++) begin
            drive(1, 32'h808, 32'(b), 0);
            tick();
        end
        drive(0, 32'h804, 32'h0, 0);
        check("status_ovf", ReadData, 32'h68);
        check("status_ovf_model", ReadData, m_read(32'h804));
        check("txdata_head", {24'h0, TxData}, 32'h41);
        drive(0, 32'h808, 32'h0, 0);
        check("txdata_read_zero", ReadData, 32'h0);
        drive(1, 32'h804, 32'h0, 0);
        tick();
        drive(0, 32'h804, 32'h0, 0);
        check("status_clr", ReadData, 32'h28);

        // Push into a full FIFO while popping.
        drive(1, 32'h808, 32'h99, 1);
        tick();
        drive(0, 32'h804, 32'h0, 0);
        check("full_pushpop", ReadData, 32'h28);
        last = 8'h00;
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            drive(0, 32'h804, 32'h0, 1);
            check("drain_byte", {24'h0, TxData}, {24'h0, q[0]});
            last = TxData;
            tick();
        end
        drive(0, 32'h804, 32'h0, 0);
        check("drain_last", {24'h0, last}, 32'h99);
        check("drain_empty", {31'h0, TxValid}, 32'h0);

        // One-cycle latency into an empty FIFO.
        drive(1, 32'h808, 32'h55, 1);
        check("lat_pre", {31'h0, TxValid}, 32'h0);
        tick();
        drive(0, 32'h804, 32'h0, 1);
        check("lat_valid", {31'h0, TxValid}, 32'h1);
        check("lat_data", {24'h0, TxData}, 32'h55);
        tick();
        check("lat_popped", {31'h0, TxValid}, 32'h0);
        check("lat_status", ReadData, 32'h10);

        // Cycle counter and unmapped reads.
        drive(1, 32'h80C, 32'h0000_FFFF, 0);
        tick();
        repeat (10) begin
            drive(0, 32'h80C, 32'h0, 0);
            tick();
        end
        drive(0, 32'h80C, 32'h0, 0);
`ifdef DATA_MEM_CYCLE_COUNTER_EN
        check("cycles_10", ReadData, 32'd10);
`else
        check("cycles_off", ReadData, 32'h0);
`endif
        drive(0, 32'h900, 32'h0, 0);
        check("unmapped_900", ReadData, 32'h0);

        drive(1, 32'h800, 32'h0000_01A5, 0);
        tick();
        drive(0, 32'h800, 32'h0, 0);
        check("led_read", ReadData, 32'hA5);
        check("led_port", {24'h0, LED}, 32'hA5);

        // Asynchronous reset with bytes queued.
        for (int b = 1; b <= 5; b++) begin
            drive(1, 32'h808, 32'(8'h60 + b), 0);
            tick();
        end
        drive(0, 32'h804, 32'h0, 0);
        check("pre_rst_count", ReadData, 32'h05);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check("arst_txvalid", {31'h0, TxValid}, 32'h0);
        check("arst_led", {24'h0, LED}, 32'h0);
        check("arst_status", ReadData, 32'h10);
        check("arst_txdata", {24'h0, TxData}, 32'h0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        drive(0, 32'h010, 32'h0, 0);
        check("ram_kept", ReadData, 32'h1234_5678);

        // Randomized traffic against the model.
        for (int it = 0; it < 500; it++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: a = ($urandom_range(0, RAM_DEPTH - 1) << 2) | $urandom_range(0, 3);
                4:          a = 32'h800 | $urandom_range(0, 3);
                5:          a = 32'h804 | $urandom_range(0, 3);
                6, 7:       a = 32'h808 | $urandom_range(0, 3);
                8:          a = 32'h80C | $urandom_range(0, 3);
                default: begin
                    if ($urandom_range(0, 1) != 0) a = 32'h200 + ($urandom_range(0, 32'h17F) << 2);
                    else a = 32'h8000_0000 | $urandom;
                end
            endcase
            drive($urandom_range(0, 1) != 0, a, $urandom,
                  (it < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            check_outputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter RAM_DEPTH, 128, number of 32-bit data RAM words (power of two, ≤512).
REQ-002 Parameter FIFO_DEPTH, 8, number of entries in the byte transmit FIFO (power of two, 2..16).
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 MemWrite  input  1  CPU store strobe, valid for the current cycle.
REQ-006 ALUResult  input  32  CPU byte address; bits [1:0] ignored (word access only).
REQ-007 WriteData  input  32  CPU store data.
REQ-008 ReadData  output  32  load data, combinational from ALUResult in the same cycle.
REQ-009 LED  output  8  LED register contents.
REQ-010 TxData  output  8  FIFO head byte.
REQ-011 TxValid  output  1  high when FIFO not empty.
REQ-012 TxReady  input  1  downstream accepts TxData when high with TxValid.

Function
REQ-013 The address map SHALL be: 0x000..(4*RAM_DEPTH-4) RAM; 0x800 LED; 0x804 STATUS; 0x808 TXDATA; 0x80C CYCLES; all others unmapped.
REQ-014 RAM reads SHALL be combinational; RAM writes SHALL occur on the CLK edge when MemWrite is high; a load and store to the same word in one cycle SHALL return the old value.
REQ-015 Unmapped reads SHALL return 0; unmapped writes SHALL have no effect.
REQ-016 LED SHALL load WriteData[7:0] on a write to 0x800; a read SHALL return {24'b0, LED}.
REQ-017 STATUS read SHALL return {25'b0, overflow, full, empty, count[3:0]}; any write to 0x804 SHALL clear overflow.
REQ-018 A write to 0x808 SHALL push WriteData[7:0] when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-019 A push to a full FIFO without a simultaneous pop SHALL be dropped and SHALL set sticky overflow.
REQ-020 A pop SHALL occur on a cycle where TxValid and TxReady are both high; TxData SHALL then advance to the next entry on the following cycle.
REQ-021 A simultaneous push and pop on a non-empty FIFO SHALL leave count unchanged.
REQ-022 A push into an empty FIFO SHALL raise TxValid on the next cycle (one-cycle latency).
REQ-023 The read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-024 TxData SHALL hold steady while TxValid is high and TxReady is low.
REQ-025 A read of 0x808 SHALL return 0 and SHALL NOT pop.
REQ-026 CYCLES SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF→0; a write to 0x80C SHALL load 0 that cycle (write takes priority over increment).

Reset
REQ-027 Asserting Reset SHALL asynchronously force LED=0, FIFO empty (TxValid=0, count=0), overflow=0 and CYCLES=0.
REQ-028 A Reset during an in-progress drain SHALL discard all queued bytes; TxData SHALL read 0 while the FIFO is empty.
REQ-029 RAM contents SHALL NOT be reset.

Configuration
REQ-030 With DATA_MEM_CYCLE_COUNTER_EN defined, CYCLES SHALL behave per REQ-026.
REQ-031 Without DATA_MEM_CYCLE_COUNTER_EN, no counter SHALL be built, 0x80C SHALL read 0, and writes to it SHALL be ignored.

Structure
REQ-032 A shared package mem_map_pkg SHALL hold the address constants (LED, STATUS, TXDATA and CYCLES addresses, and the RAM base) and the STATUS bit positions.
REQ-033 The FIFO SHALL be a sub-module tx_fifo with push/pop/full/empty/count ports; decode, RAM, LED and counter logic SHALL stay in data_mem_responder.

Verification
REQ-034 Store 0xDEADBEEF to 0x010, then load 0x010 -> ReadData=0xDEADBEEF; a load of 0x013 returns the same value.
REQ-035 With TxReady=0, push 0x41..0x48 (8 bytes), then push 0x49 -> STATUS=0x00000068 (count=8, full, overflow), TxData=0x41.
REQ-036 With TxReady=1, push 0x55 into an empty FIFO -> TxValid=1 on the next cycle and popped one cycle later; STATUS returns to 0x10.
REQ-037 With the FIFO full and TxReady=1, push 0x99 -> count stays 8, overflow stays 0, and 0x99 emerges last.
REQ-038 Assert Reset with 5 bytes queued and LED=0xA5 -> TxValid=0, LED=0x00 and STATUS=0x10 immediately, without waiting for CLK.
REQ-039 Write 0x80C, then read it 10 cycles later -> ReadData=10 with DATA_MEM_CYCLE_COUNTER_EN defined, or 0 without it; a load of 0x900 returns 0.
